// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and FSM encoding for the 2-read/1-write register file.
// Imported by the interface, the word register and the top level.
package reg_file_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_DEF = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Port bundle between the decode stage (master) and the register file (slave).
import reg_file_pkg::*;

interface reg_file_2r1w_if #(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              WE;
   logic [ADDR_W-1:0] WADDR;
   logic [WIDTH-1:0]  WDATA;
   logic              RE;
   logic [ADDR_W-1:0] RADDR1;
   logic [ADDR_W-1:0] RADDR2;
   logic              CLR;
   logic [WIDTH-1:0]  RDATA1;
   logic [WIDTH-1:0]  RDATA2;
   logic              BUSY;

   modport master (
      output WE, WADDR, WDATA, RE, RADDR1, RADDR2, CLR,
      input  RDATA1, RDATA2, BUSY
   );

   modport slave (
      input  WE, WADDR, WDATA, RE, RADDR1, RADDR2, CLR,
      output RDATA1, RDATA2, BUSY
   );
endinterface

// File: rtl/reg_file_2r1w_word.sv
// One storage word: load enable, synchronous clear, asynchronous active-high reset.
import reg_file_pkg::*;

module reg_word #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_file_2r1w.sv
// DEPTH x WIDTH register file: one write port, two registered read ports,
// write-through bypass, optional hardwired-zero entry 0 and a clear sweep.
import reg_file_pkg::*;

module reg_file_2r1w #(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF
) (
   input  logic            C,
   input  logic            R,
   reg_file_2r1w_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;

   logic [DEPTH-1:0]            dec;
   logic [DEPTH-1:0]            clr_vec;
   logic [DEPTH-1:0][WIDTH-1:0] words;
   logic                        wr_ok;

   logic [WIDTH-1:0] rdata1, rdata2;
   logic [WIDTH-1:0] rd1_nxt, rd2_nxt;

   // A write lands only in IDLE, loses to a simultaneous CLR, and never touches a hardwired zero.
   assign wr_ok = (state == ST_IDLE) && bus.WE && !bus.CLR &&
                  !((ZERO_REG != 0) && (bus.WADDR == '0));

   generate
      if (DEPTH == 32) begin : g_dec_chain
         logic [3:0] lo;
         logic [7:0] hi;
         assign lo = 4'(1) << bus.WADDR[1:0];
         assign hi = 8'(1) << bus.WADDR[4:2];
         for (genvar i = 0; i < 32; i++) begin : g_and
            assign dec[i] = hi[i / 4] & lo[i % 4];
         end
      end else begin : g_dec_bin
         assign dec = DEPTH'(1) << bus.WADDR;
      end
   endgenerate

   // NOTE: the storage array is reset like any other state so a reset mid-sweep leaves no stale data.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_word
         assign clr_vec[i] = (state == ST_CLEAR) && (cnt == ADDR_W'(i));
         reg_word #(.WIDTH(WIDTH)) u_word (
            .clk  (C),
            .rst  (R),
            .load (wr_ok && dec[i]),
            .clr  (clr_vec[i]),
            .d    (bus.WDATA),
            .q    (words[i])
         );
      end
   endgenerate

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         ST_IDLE: begin
            if (bus.CLR) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_nxt = cnt + ADDR_W'(1);
            if (cnt == LAST_ADDR) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Read select: array data, overridden by the in-flight write, overridden by the zero entry.
   always_comb begin
      rd1_nxt = words[bus.RADDR1];
      rd2_nxt = words[bus.RADDR2];
      if (wr_ok && (bus.RADDR1 == bus.WADDR)) rd1_nxt = bus.WDATA;
      if (wr_ok && (bus.RADDR2 == bus.WADDR)) rd2_nxt = bus.WDATA;
      if ((ZERO_REG != 0) && (bus.RADDR1 == '0)) rd1_nxt = '0;
      if ((ZERO_REG != 0) && (bus.RADDR2 == '0)) rd2_nxt = '0;
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         rdata1 <= '0;
         rdata2 <= '0;
      end else if (bus.RE) begin
         rdata1 <= rd1_nxt;
         rdata2 <= rd2_nxt;
      end
   end

   assign bus.RDATA1 = rdata1;
   assign bus.RDATA2 = rdata2;
   assign bus.BUSY   = (state == ST_CLEAR);

endmodule
